// File: rtl/quickq_pkg.sv
// quickq_pkg: shared QuickQ constants and the dequeue-reader state type.
// Used by the control FSM, the fill logic and the dequeue reader, so the
// sentinel and head address stay consistent across all of them.
package quickq_pkg;
   localparam logic [31:0] EMPTY_VAL = 32'hFFFF_FFFF;
   localparam logic [31:0] HEAD_ADDR = 32'd0;
   typedef enum logic [2:0] {IDLE, RD_REQ, RD_DATA, POP, POP_WAIT, ERR} deq_state_t;
endpackage

// File: rtl/quickq_out_fifo2.sv
// quickq_out_fifo2: 2-entry valid/ready output buffer with occupancy count.
// Ports: clk, rst (sync, active-low); push_i/push_data_i write side;
// valid_o/ready_i/data_o stream side (data_o is the oldest entry);
// count_o is the registered occupancy (0..2).
// The writer must never push while count_o==2 unless popping in the same cycle.
module quickq_out_fifo2 #(
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push_i,
   input  logic [DATA_W-1:0] push_data_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [DATA_W-1:0] data_o,
   output logic [1:0]        count_o
);
   logic [DATA_W-1:0] head_q, head_d, tail_q, tail_d;
   logic [1:0]        count_q, count_d, occ;
   logic              pop;
   always_comb begin
      pop     = (count_q != 2'd0) && ready_i;
      // occupancy after this cycle's pop decides which slot a push lands in
      occ     = count_q - {1'b0, pop};
      count_d = occ + {1'b0, push_i};
      head_d  = (push_i && occ == 2'd0) ? push_data_i : (pop ? tail_q : head_q);
      tail_d  = (push_i && occ == 2'd1) ? push_data_i : tail_q;
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end
   assign valid_o = (count_q != 2'd0);
   assign data_o  = head_q;
   assign count_o = count_q;
endmodule

// File: rtl/quickq_deq_reader.sv
// quickq_deq_reader: reads the QuickQ head from BRAM, streams it out, then
// issues a one-cycle deq and waits for the control FSM to finish shifting.
// Ports: clk, rst (sync, active-low); q_empty/q_busy from the control FSM;
// bram_re/bram_addr/bram_rdata head read (1-cycle read latency); deq command;
// out_valid/out_ready/out_data output stream; underflow_err sticky flag set
// when the head holds the sentinel; pop_count counts completed pops (wraps).
module quickq_deq_reader #(
   parameter int                DATA_W    = 32,
   parameter int                ADDR_W    = 32,
   parameter logic [ADDR_W-1:0] HEAD_ADDR = quickq_pkg::HEAD_ADDR,
   parameter logic [DATA_W-1:0] EMPTY_VAL = quickq_pkg::EMPTY_VAL
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              q_empty,
   input  logic              q_busy,
   input  logic [DATA_W-1:0] bram_rdata,
   output logic              bram_re,
   output logic [ADDR_W-1:0] bram_addr,
   output logic              deq,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              underflow_err,
   output logic [15:0]       pop_count
);
   import quickq_pkg::*;
   deq_state_t  state_q, state_d;
   logic [15:0] pop_count_q, pop_count_d;
   logic        err_q, err_d, push;
   logic [1:0]  buf_count;
   quickq_out_fifo2 #(.DATA_W(DATA_W)) u_buf (
      .clk        (clk),
      .rst        (rst),
      .push_i     (push),
      .push_data_i(bram_rdata),
      .valid_o    (out_valid),
      .ready_i    (out_ready),
      .data_o     (out_data),
      .count_o    (buf_count)
   );
   always_comb begin
      state_d     = state_q;
      pop_count_d = pop_count_q;
      err_d       = err_q;
      push        = 1'b0;
      bram_re     = 1'b0;
      bram_addr   = '0;
      deq         = 1'b0;
      case (state_q)
         // registered buf_count only: a slot freed this cycle is not counted,
         // which keeps out_ready off the path to bram_re
         IDLE:     state_d = (!q_empty && !q_busy && buf_count < 2'd2) ? RD_REQ : IDLE;
         RD_REQ: begin
            bram_re   = 1'b1;
            bram_addr = HEAD_ADDR;
            state_d   = RD_DATA;
         end
         RD_DATA: begin
            push    = (bram_rdata != EMPTY_VAL);
            err_d   = err_q | !push;
            state_d = push ? POP : ERR;
         end
         POP: begin
            deq     = 1'b1;
            state_d = POP_WAIT;
         end
         POP_WAIT: begin
            pop_count_d = q_busy ? pop_count_q : pop_count_q + 16'd1;
            state_d     = q_busy ? POP_WAIT : IDLE;
         end
         default:  state_d = state_q;
      endcase
   end
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= IDLE;
         pop_count_q <= '0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         pop_count_q <= pop_count_d;
         err_q       <= err_d;
      end
   end
   assign underflow_err = err_q;
   assign pop_count     = pop_count_q;
endmodule
